// File: rtl/i2s_rx_frame_fifo_if.sv
// i2s_rx_frame_fifo_if
//   Stereo frame stream leaving the I2S receiver FIFO.
//   master : frame producer (receiver) - drives out_left/out_right/out_valid,
//            samples out_ready
//   slave  : frame consumer - samples data/valid, drives out_ready
//   Signals:
//     out_left   [DATA_WIDTH-1:0]  left sample of head frame
//     out_right  [DATA_WIDTH-1:0]  right sample of head frame
//     out_valid                    head frame valid
//     out_ready                    consumer accepts head frame
interface i2s_rx_frame_fifo_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// i2s_rx_frame_fifo
//   Stereo I2S receiver. Oversamples sck/ws/sd in the clk domain, deserialises
//   left/right words (Philips I2S when MODE=0, left-justified when MODE=1) and
//   pushes complete stereo frames into a first-word-fall-through FIFO.
//   Ports:
//     clk           system clock, >= 4x sck
//     reset         asynchronous active-high reset
//     sck, ws, sd   I2S pins (ws: 0 = left, 1 = right; sd MSB first)
//     frame         frame stream (out_left/out_right/out_valid/out_ready)
//     fill_level    frames currently held in the FIFO
//     overflow      sticky flag: a completed frame was dropped on a full FIFO
//     overflow_clr  clears overflow; a drop in the same cycle takes priority
module i2s_rx_frame_fifo #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned MODE       = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sck,
  input  logic                        ws,
  input  logic                        sd,
  i2s_rx_frame_fifo_if.master         frame,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int unsigned IDX_W      = $clog2(SLOT_WIDTH + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  // slot index carrying the MSB: one sck late in Philips framing
  localparam int unsigned MSB_OFFSET = (MODE == 0) ? 1 : 0;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  // ---------------------------------------------------------------- pins
  logic sck_q, sck_qq, ws_q, sd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
      ws_q   <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      sck_q  <= sck;
      sck_qq <= sck_q;
      ws_q   <= ws;
      sd_q   <= sd;
    end
  end

  // ------------------------------------------------------------- capture
  logic [1:0]            state;
  logic                  ws_prev;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] left_word;
  logic [DATA_WIDTH-1:0] right_word;
  logic                  push_req;

  logic                  bit_event;
  logic                  ws_edge;
  logic [IDX_W-1:0]      cur_idx;
  logic [31:0]           cur_idx32;
  logic [IDX_W-1:0]      idx_next;
  logic [DATA_WIDTH-1:0] shift_next;

  assign bit_event = sck_q & ~sck_qq;
  assign ws_edge   = (ws_q != ws_prev);

  always_comb begin
    cur_idx   = ws_edge ? '0 : bit_idx;
    cur_idx32 = 32'(cur_idx);
    idx_next  = (cur_idx32 < SLOT_WIDTH) ? cur_idx + IDX_W'(1) : cur_idx;
    // a new slot starts from zero so a short slot leaves its LSBs cleared
    shift_next = ws_edge ? '0 : shift_reg;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (cur_idx32 == MSB_OFFSET + DATA_WIDTH - 1 - i)
        shift_next[i] = sd_q;
    end
  end

  // The completed word is taken from shift_reg (pre-edge value) on the ws
  // edge; the bit arriving with the edge only feeds the new slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SYNC;
      ws_prev    <= 1'b0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      left_word  <= '0;
      right_word <= '0;
      push_req   <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (bit_event) begin
        ws_prev   <= ws_q;
        bit_idx   <= idx_next;
        shift_reg <= shift_next;
        if (ws_edge) begin
          case (state)
            ST_SYNC: begin
              if (!ws_q) state <= ST_LEFT;
            end
            ST_LEFT: begin
              if (ws_q) begin
                left_word <= shift_reg;
                state     <= ST_RIGHT;
              end
            end
            ST_RIGHT: begin
              if (!ws_q) begin
                right_word <= shift_reg;
                push_req   <= 1'b1;
                state      <= ST_LEFT;
              end
            end
            default: state <= ST_SYNC;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, pop, push_do;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = (count != '0) & frame.out_ready;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push_do = push_req & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_left[i]  <= '0;
        mem_right[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_do) begin
        mem_left[wr_ptr]  <= left_word;
        mem_right[wr_ptr] <= right_word;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_do, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

  assign frame.out_left  = mem_left[rd_ptr];
  assign frame.out_right = mem_right[rd_ptr];
  assign frame.out_valid = (count != '0);
  assign fill_level      = count;

endmodule

// File: tb/tb_i2s_rx_frame_fifo.sv
module tb_i2s_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic [2:0] ws_v = '0;
  logic [2:0] sd_v = '0;
  logic [2:0] clr_v = '0;

  logic [2:0] fill_a, fill_b, fill_c;
  logic       ovf_a, ovf_b, ovf_c;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // A: Philips, 24/32, depth 4   B: left-justified 16/32   C: left-justified 24/16
  i2s_rx_frame_fifo_if #(.DATA_WIDTH(24)) if_a ();
  i2s_rx_frame_fifo_if #(.DATA_WIDTH(16)) if_b ();
  i2s_rx_frame_fifo_if #(.DATA_WIDTH(24)) if_c ();

  i2s_rx_frame_fifo #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .MODE(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .sck(sck), .ws(ws_v[0]), .sd(sd_v[0]),
    .frame(if_a.master), .fill_level(fill_a), .overflow(ovf_a), .overflow_clr(clr_v[0]));

  i2s_rx_frame_fifo #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .MODE(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .sck(sck), .ws(ws_v[1]), .sd(sd_v[1]),
    .frame(if_b.master), .fill_level(fill_b), .overflow(ovf_b), .overflow_clr(clr_v[1]));

  i2s_rx_frame_fifo #(.DATA_WIDTH(24), .SLOT_WIDTH(16), .MODE(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .sck(sck), .ws(ws_v[2]), .sd(sd_v[2]),
    .frame(if_c.master), .fill_level(fill_c), .overflow(ovf_c), .overflow_clr(clr_v[2]));

  // pop monitors
  int unsigned     pops_a = 0, pops_b = 0, pops_c = 0;
  logic [23:0]     last_la = '0, last_ra = '0;
  logic [15:0]     last_lb = '0, last_rb = '0;
  logic [23:0]     last_lc = '0, last_rc = '0;

  always @(posedge clk) begin
    if (if_a.out_valid && if_a.out_ready) begin
      pops_a  <= pops_a + 1;
      last_la <= if_a.out_left;
      last_ra <= if_a.out_right;
    end
    if (if_b.out_valid && if_b.out_ready) begin
      pops_b  <= pops_b + 1;
      last_lb <= if_b.out_left;
      last_rb <= if_b.out_right;
    end
    if (if_c.out_valid && if_c.out_ready) begin
      pops_c  <= pops_c + 1;
      last_lc <= if_c.out_left;
      last_rc <= if_c.out_right;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One sck period = 8 clk. With pulse set, out_ready of A is raised for the
  // single clk cycle in which the frame completed by this bit is pushed.
  task automatic send_bit(input int unsigned inst, input logic w, input logic d, input logic pulse);
    @(negedge clk);
    sck = 1'b0;
    ws_v[inst] = w;
    sd_v[inst] = d;
    repeat (3) @(negedge clk);
    sck = 1'b1;
    if (pulse) begin
      repeat (2) @(negedge clk);
      if_a.out_ready = 1'b1;
      @(negedge clk);
      if_a.out_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // Non-data positions carry 1s so ignored bits are visible if captured.
  task automatic send_slot(input int unsigned inst, input logic w, input logic [31:0] word,
                           input int unsigned nbits, input int unsigned slot, input int unsigned mode);
    for (int unsigned i = 0; i < slot; i++) begin
      logic d;
      int   off;
      d   = 1'b1;
      off = int'(i) - ((mode == 0) ? 1 : 0);
      if (off >= 0 && off < int'(nbits)) d = word[int'(nbits) - 1 - off];
      send_bit(inst, w, d, 1'b0);
    end
  endtask

  task automatic send_a_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(0, 1'b0, {8'h00, l}, 24, 32, 0);
    send_slot(0, 1'b1, {8'h00, r}, 24, 32, 0);
  endtask

  logic [23:0] fl [5];
  logic [23:0] fr [5];

  initial begin
    int unsigned base;
    fl = '{24'h111111, 24'h2468AC, 24'h800001, 24'h0F0F0F, 24'hFEDCBA};
    fr = '{24'hABCDEF, 24'h13579B, 24'h7FFFFE, 24'hF0F0F0, 24'h012345};
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    if_c.out_ready = 1'b0;

    // ---- reset state
    do_reset();
    check("rst_valid", {31'd0, if_a.out_valid}, 32'd0);
    check("rst_left", {8'd0, if_a.out_left}, 32'd0);
    check("rst_right", {8'd0, if_a.out_right}, 32'd0);
    check("rst_fill", {29'd0, fill_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);

    // ---- mid-stream reset discards FIFO and partial frame
    send_slot(0, 1'b1, 32'h0, 24, 32, 0);
    send_a_frame(24'h111111, 24'h222222);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_fill", {29'd0, fill_a}, 32'd1);
    for (int unsigned i = 0; i < 15; i++) send_bit(0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("mid_rst_fill", {29'd0, fill_a}, 32'd0);
    check("mid_rst_valid", {31'd0, if_a.out_valid}, 32'd0);
    check("mid_rst_left", {8'd0, if_a.out_left}, 32'd0);

    // ---- MODE 0 capture, one valid pulse
    if_a.out_ready = 1'b1;
    base = pops_a;
    send_slot(0, 1'b1, {8'h00, 24'h333333}, 24, 32, 0);
    send_a_frame(24'hA5C3F1, 24'h123456);
    check("no_early_frame", pops_a - base, 32'd0);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("m0_pops", pops_a - base, 32'd1);
    check("m0_left", {8'd0, last_la}, 32'h00A5C3F1);
    check("m0_right", {8'd0, last_ra}, 32'h00123456);
    check("m0_valid_after", {31'd0, if_a.out_valid}, 32'd0);
    if_a.out_ready = 1'b0;

    // ---- overflow: 5 frames into depth 4
    do_reset();
    send_slot(0, 1'b1, 32'h0, 24, 32, 0);
    for (int unsigned k = 0; k < 5; k++) send_a_frame(fl[k], fr[k]);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_fill", {29'd0, fill_a}, 32'd4);
    check("ovf_flag", {31'd0, ovf_a}, 32'd1);
    for (int unsigned k = 0; k < 4; k++) begin
      check("ovf_head_l", {8'd0, if_a.out_left}, {8'd0, fl[k]});
      check("ovf_head_r", {8'd0, if_a.out_right}, {8'd0, fr[k]});
      if_a.out_ready = 1'b1;
      @(negedge clk);
      if_a.out_ready = 1'b0;
    end
    check("ovf_drained_valid", {31'd0, if_a.out_valid}, 32'd0);
    check("ovf_drained_fill", {29'd0, fill_a}, 32'd0);
    check("ovf_sticky", {31'd0, ovf_a}, 32'd1);
    clr_v[0] = 1'b1;
    @(negedge clk);
    clr_v[0] = 1'b0;
    check("ovf_cleared", {31'd0, ovf_a}, 32'd0);

    // ---- full + push + pop in the same cycle
    do_reset();
    send_slot(0, 1'b1, 32'h0, 24, 32, 0);
    for (int unsigned k = 0; k < 5; k++) send_a_frame(fl[k], fr[k]);
    repeat (4) @(negedge clk);
    check("full_fill", {29'd0, fill_a}, 32'd4);
    send_bit(0, 1'b0, 1'b1, 1'b1);
    check("pp_fill", {29'd0, fill_a}, 32'd4);
    check("pp_ovf", {31'd0, ovf_a}, 32'd0);
    check("pp_head", {8'd0, if_a.out_left}, {8'd0, fl[1]});
    repeat (3) begin
      if_a.out_ready = 1'b1;
      @(negedge clk);
      if_a.out_ready = 1'b0;
    end
    check("pp_last_l", {8'd0, if_a.out_left}, {8'd0, fl[4]});
    check("pp_last_r", {8'd0, if_a.out_right}, {8'd0, fr[4]});

    // ---- MODE 1, 16-bit words, trailing junk ignored
    do_reset();
    if_b.out_ready = 1'b1;
    base = pops_b;
    send_slot(1, 1'b1, 32'h0, 16, 32, 1);
    send_slot(1, 1'b0, 32'h0000BEEF, 16, 32, 1);
    send_slot(1, 1'b1, 32'h00000F0F, 16, 32, 1);
    send_bit(1, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("m1_pops", pops_b - base, 32'd1);
    check("m1_left", {16'd0, last_lb}, 32'h0000BEEF);
    check("m1_right", {16'd0, last_rb}, 32'h00000F0F);

    // ---- short slot: 16 bits into a 24-bit word
    do_reset();
    if_c.out_ready = 1'b1;
    base = pops_c;
    send_slot(2, 1'b1, 32'h0, 16, 16, 1);
    send_slot(2, 1'b0, 32'h0000FFFF, 16, 16, 1);
    send_slot(2, 1'b1, 32'h00001234, 16, 16, 1);
    send_bit(2, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    check("short_pops", pops_c - base, 32'd1);
    check("short_left", {8'd0, last_lc}, 32'h00FFFF00);
    check("short_right", {8'd0, last_rc}, 32'h00123400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
